// File: rtl/store_align_unit_if.sv
// Command and memory-write bus of the store alignment unit.
// The execute stage and the memory model sit on the master side;
// the store alignment unit sits on the slave side.
interface store_align_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  aluopselect;
   logic [2:0]  aluoperation;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        done;
   logic        err;

   modport master (
      output req_valid, aluopselect, aluoperation, addr, wdata, mem_ack,
      input  req_ready, mem_req, mem_addr, mem_wdata, mem_be, done, err
   );

   modport slave (
      input  req_valid, aluopselect, aluoperation, addr, wdata, mem_ack,
      output req_ready, mem_req, mem_addr, mem_wdata, mem_be, done, err
   );
endinterface

// File: rtl/store_align_unit.sv
// Store alignment unit: takes a byte/half/word store, lane-aligns it into
// 32-bit little-endian words with byte enables and issues one or two
// word writes on a req/ack port. Stores crossing a word boundary split
// into two beats; the second beat address wraps at 2^32.
module store_align_unit (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   store_align_unit_if.slave bus
);

   localparam logic [2:0] MEM_WRITE = 3'b100;
   localparam logic [2:0] OP_SB     = 3'b000;
   localparam logic [2:0] OP_SH     = 3'b001;
   localparam logic [2:0] OP_SW     = 3'b011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT1 = 2'd1,
      BEAT2 = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state, state_next;

   // Registered memory-port fields and the parked second beat.
   logic        req_q,     req_next;
   logic [31:0] addr_q,    addr_next;
   logic [3:0]  be_q,      be_next;
   logic [31:0] data_q,    data_next;
   logic [3:0]  hi_be_q,   hi_be_next;
   logic [31:0] hi_data_q, hi_data_next;
   logic        err_q,     err_next;

   // Alignment of the incoming command.
   logic [1:0]  off;
   logic [3:0]  base_mask;
   logic        size_legal;
   logic [31:0] lane_mask;
   logic [31:0] data_masked;
   logic [7:0]  be8;
   logic [63:0] data64;
   logic        ready;
   logic        accept;

   // Ready only in IDLE with enable, and held low while reset is asserted.
   assign ready  = (state == IDLE) && enable && reset;
   assign accept = bus.req_valid && ready;

   assign bus.req_ready = ready;
   assign bus.mem_req   = req_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_be    = be_q;
   assign bus.mem_wdata = data_q;
   assign bus.done      = (state == DONE);
   assign bus.err       = (state == DONE) && err_q;

   // Size decode and lane alignment of the command presented on the bus.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      base_mask  = 4'h0;
      size_legal = 1'b0;
      case (bus.aluoperation)
         OP_SB: begin base_mask = 4'h1; size_legal = 1'b1; end
         OP_SH: begin base_mask = 4'h3; size_legal = 1'b1; end
         OP_SW: begin base_mask = 4'hF; size_legal = 1'b1; end
         default: begin base_mask = 4'h0; size_legal = 1'b0; end
      endcase
      off         = bus.addr[1:0];
      lane_mask   = {{8{base_mask[3]}}, {8{base_mask[2]}},
                     {8{base_mask[1]}}, {8{base_mask[0]}}};
      data_masked = bus.wdata & lane_mask;
      be8         = {4'b0000, base_mask} << off;
      data64      = {32'h0, data_masked} << {off, 3'b000};
   end

   // Next-state and next-output logic of the command FSM.
   always_comb begin
      state_next   = state;
      req_next     = req_q;
      addr_next    = addr_q;
      be_next      = be_q;
      data_next    = data_q;
      hi_be_next   = hi_be_q;
      hi_data_next = hi_data_q;
      err_next     = err_q;
      case (state)
         IDLE: begin
            if (accept && (bus.aluopselect == MEM_WRITE)) begin
               if (size_legal) begin
                  state_next   = BEAT1;
                  req_next     = 1'b1;
                  addr_next    = {bus.addr[31:2], 2'b00};
                  be_next      = be8[3:0];
                  data_next    = data64[31:0];
                  hi_be_next   = be8[7:4];
                  hi_data_next = data64[63:32];
                  err_next     = 1'b0;
               end else begin
                  state_next = DONE;
                  err_next   = 1'b1;
               end
            end
         end
         BEAT1: begin
            if (bus.mem_ack) begin
               if (hi_be_q != 4'h0) begin
                  state_next = BEAT2;
                  addr_next  = addr_q + 32'd4;
                  be_next    = hi_be_q;
                  data_next  = hi_data_q;
               end else begin
                  state_next = DONE;
                  req_next   = 1'b0;
                  addr_next  = 32'h0;
                  be_next    = 4'h0;
                  data_next  = 32'h0;
               end
            end
         end
         BEAT2: begin
            if (bus.mem_ack) begin
               state_next = DONE;
               req_next   = 1'b0;
               addr_next  = 32'h0;
               be_next    = 4'h0;
               data_next  = 32'h0;
            end
         end
         DONE: begin
            state_next = IDLE;
            err_next   = 1'b0;
         end
         default: state_next = IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (!reset) begin
         state     <= IDLE;
         req_q     <= 1'b0;
         addr_q    <= 32'h0;
         be_q      <= 4'h0;
         data_q    <= 32'h0;
         hi_be_q   <= 4'h0;
         hi_data_q <= 32'h0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_next;
         req_q     <= req_next;
         addr_q    <= addr_next;
         be_q      <= be_next;
         data_q    <= data_next;
         hi_be_q   <= hi_be_next;
         hi_data_q <= hi_data_next;
         err_q     <= err_next;
      end
   end

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench for store_align_unit. A byte-level reference model
// fills scoreboard queues at issue time; a monitor on the falling edge
// compares every presented beat and every done pulse against them.
module tb_store_align_unit;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } beat_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;

   store_align_unit_if bus ();

   store_align_unit dut (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   beat_t beat_q[$];
   bit    done_q[$];

   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   int  last_ack_cyc = 0;
   int  accept_cyc = 0;
   bit  busy = 1'b0;
   bit  first_pending = 1'b0;
   bit  ack_block = 1'b0;
   bit  rand_en = 1'b0;
   int  fixed_stall = 0;
   int  stall_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: place each stored byte at its own byte address and
   // group the bytes by the word they fall in.
   task automatic push_beats(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
      int          n;
      int          lane;
      bit          two;
      beat_t       b0, b1;
      logic [31:0] w0, ba;
      n   = (op == 3'b000) ? 1 : (op == 3'b001) ? 2 : 4;
      w0  = a & 32'hFFFF_FFFC;
      b0  = '{addr: w0, be: 4'h0, data: 32'h0};
      b1  = '{addr: w0 + 32'd4, be: 4'h0, data: 32'h0};
      two = 1'b0;
      for (int i = 0; i < n; i++) begin
         ba   = a + 32'(i);
         lane = int'(ba[1:0]);
         if ((ba & 32'hFFFF_FFFC) == w0) begin
            b0.be[lane] = 1'b1;
            b0.data[8*lane +: 8] = d[8*i +: 8];
         end else begin
            two = 1'b1;
            b1.be[lane] = 1'b1;
            b1.data[8*lane +: 8] = d[8*i +: 8];
         end
      end
      beat_q.push_back(b0);
      if (two) beat_q.push_back(b1);
   endtask

   // Present one command for one edge; record expectations for the monitor.
   task automatic send(input logic [2:0] sel, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d);
      bit store, legal;
      store = (sel == 3'b100);
      legal = (op == 3'b000) || (op == 3'b001) || (op == 3'b011);
      if (store && legal) push_beats(op, a, d);
      if (store) done_q.push_back(!legal);
      bus.req_valid    = 1'b1;
      bus.aluopselect  = sel;
      bus.aluoperation = op;
      bus.addr         = a;
      bus.wdata        = d;
      @(posedge clock);
      #1;
      bus.req_valid    = 1'b0;
      bus.aluopselect  = 3'($urandom);
      bus.aluoperation = 3'($urandom);
      bus.addr         = $urandom;
      bus.wdata        = $urandom;
      if (store) begin
         busy          = 1'b1;
         accept_cyc    = cyc;
         last_ack_cyc  = cyc;
         first_pending = legal;
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 100) begin
         @(posedge clock);
         #1;
         if (rand_en) enable = 1'($urandom_range(0, 1));
         k++;
      end
      enable = 1'b1;
      if (busy) begin
         check("cmd_timeout", 64'(busy), 64'd0);
         beat_q.delete();
         done_q.delete();
         busy = 1'b0;
         first_pending = 1'b0;
      end
   endtask

   task automatic issue(input logic [2:0] sel, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] d);
      send(sel, op, a, d);
      wait_idle();
   endtask

   // Memory model: acknowledges beats after a chosen stall.
   initial begin
      bus.mem_ack = 1'b0;
      forever begin
         @(posedge clock);
         #2;
         if (ack_block) bus.mem_ack = 1'b0;
         else if (!bus.mem_req) bus.mem_ack = 1'($urandom_range(0, 1));
         else if (stall_cnt > 0) begin
            bus.mem_ack = 1'b0;
            stall_cnt--;
         end else begin
            bus.mem_ack = 1'b1;
            stall_cnt = (fixed_stall >= 0) ? fixed_stall : $urandom_range(0, 2);
         end
      end
   end

   // Monitor: compares presented beats, done pulses and req_ready.
   always @(negedge clock) begin
      cyc++;
      check("req_ready", 64'(bus.req_ready), 64'(!busy && enable && reset));
      if (bus.mem_req) begin
         if (first_pending) begin
            check("first_beat_latency", 64'(cyc), 64'(accept_cyc + 1));
            first_pending = 1'b0;
         end
         if (beat_q.size() == 0) begin
            check("spurious_mem_req", 64'(bus.mem_req), 64'd0);
         end else begin
            check("mem_addr", 64'(bus.mem_addr), 64'(beat_q[0].addr));
            check("mem_be", 64'(bus.mem_be), 64'(beat_q[0].be));
            check("mem_wdata", 64'(bus.mem_wdata), 64'(beat_q[0].data));
            if (bus.mem_ack) begin
               void'(beat_q.pop_front());
               last_ack_cyc = cyc;
            end
         end
      end
      if (bus.done) begin
         if (done_q.size() == 0) begin
            check("spurious_done", 64'(bus.done), 64'd0);
         end else begin
            check("err", 64'(bus.err), 64'(done_q.pop_front()));
            check("beats_left_at_done", 64'(beat_q.size()), 64'd0);
            check("done_latency", 64'(cyc), 64'(last_ack_cyc + 1));
            busy = 1'b0;
         end
      end else begin
         check("err_without_done", 64'(bus.err), 64'd0);
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
      check({tag, "_mem_req"},   64'(bus.mem_req),   64'd0);
      check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
      check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
      check({tag, "_mem_be"},    64'(bus.mem_be),    64'd0);
      check({tag, "_done"},      64'(bus.done),      64'd0);
      check({tag, "_err"},       64'(bus.err),       64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [2:0]  sel, op;
      logic [31:0] a;
      bus.req_valid    = 1'b0;
      bus.aluopselect  = 3'b000;
      bus.aluoperation = 3'b000;
      bus.addr         = 32'h0;
      bus.wdata        = 32'h0;

      // Reset state, with enable high to show req_ready is still forced low.
      enable = 1'b1;
      reset  = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_all_zero("reset");
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("ready_after_reset", 64'(bus.req_ready), 64'd1);

      // Zero-wait directed stores.
      fixed_stall = 0;
      stall_cnt   = 0;
      issue(3'b100, 3'b011, 32'h0000_0100, 32'hDEAD_BEEF);
      for (int o = 0; o < 4; o++)
         issue(3'b100, 3'b000, 32'h0000_0200 + 32'(o), 32'h1234_56A5);
      issue(3'b100, 3'b001, 32'h0000_03FF, 32'h0000_CAFE);

      // Split SW with a 3-cycle stall on each beat.
      fixed_stall = 3;
      stall_cnt   = 3;
      issue(3'b100, 3'b011, 32'h0000_0602, 32'h89AB_CDEF);

      // Illegal size and non-store command.
      fixed_stall = 0;
      stall_cnt   = 0;
      issue(3'b100, 3'b111, 32'h0000_0700, 32'h5555_AAAA);
      issue(3'b001, 3'b011, 32'h0000_0704, 32'h1111_2222);
      @(posedge clock);
      #1;

      // enable low in IDLE: command must not be taken.
      enable           = 1'b0;
      bus.req_valid    = 1'b1;
      bus.aluopselect  = 3'b100;
      bus.aluoperation = 3'b011;
      bus.addr         = 32'h0000_0800;
      bus.wdata        = 32'hFFFF_0000;
      repeat (3) begin
         @(posedge clock);
         #1;
         check("disabled_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.req_valid = 1'b0;
      enable        = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      // Reset during the beat-2 stall of a split store.
      fixed_stall = 3;
      stall_cnt   = 3;
      send(3'b100, 3'b011, 32'h0000_0902, 32'hCAFE_F00D);
      k = 0;
      while (!(bus.mem_req && bus.mem_be == 4'h3) && k < 50) begin
         @(posedge clock);
         #1;
         k++;
      end
      check("beat2_reached", 64'(bus.mem_be), 64'h3);
      ack_block = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      beat_q.delete();
      done_q.delete();
      busy          = 1'b0;
      first_pending = 1'b0;
      check_all_zero("abort");
      @(posedge clock);
      #1;
      reset       = 1'b1;
      ack_block   = 1'b0;
      fixed_stall = -1;
      stall_cnt   = 0;
      repeat (3) @(posedge clock);
      #1;

      // Address wrap on a split store.
      issue(3'b100, 3'b011, 32'hFFFF_FFFD, 32'h0102_0304);
      issue(3'b100, 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF);

      // Randomized commands with random stalls and enable toggling in flight.
      rand_en = 1'b1;
      for (int i = 0; i < 80; i++) begin
         sel = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b100;
         case ($urandom_range(0, 7))
            0:       op = 3'($urandom);
            1, 2:    op = 3'b000;
            3, 4:    op = 3'b001;
            default: op = 3'b011;
         endcase
         a = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
         issue(sel, op, a, $urandom);
      end
      rand_en = 1'b0;

      repeat (5) @(posedge clock);
      #1;
      check("beat_q_drained", 64'(beat_q.size()), 64'd0);
      check("done_q_drained", 64'(done_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/store_align_unit.md
# store_align_unit

Store-path counterpart to the datapath ALU's load/extract logic. Accepts a store command (size, byte address, register data), lane-aligns the data into 32-bit little-endian memory words with byte enables, and drives a req/ack memory write port. Misaligned stores that cross a word boundary are split into two sequential word writes. Sits between the execute stage (`aluopselect`/`aluoperation` decode) and the data-memory write port.

## Interface
Parameters:
- None. Datapath is fixed at 32 bits; the byte address is 32 bits.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  gates acceptance of new commands only.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  unit can accept a command.
- `aluopselect`  in  3  command class; only `3'b100` (MEM_WRITE) is a store.
- `aluoperation`  in  3  store size: `3'b000` SB, `3'b001` SH, `3'b011` SW; others illegal.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-justified (SB uses [7:0], SH uses [15:0]).
- `mem_req`  out  1  memory write request.
- `mem_addr`  out  32  word-aligned address; bits [1:0] always 0.
- `mem_wdata`  out  32  lane-aligned write data.
- `mem_be`  out  4  byte enables; bit i covers `mem_wdata[8i+7:8i]`.
- `mem_ack`  in  1  memory accepted the current beat.
- `done`  out  1  one-cycle pulse when a command completes.
- `err`  out  1  qualifies `done`: illegal size code, no memory access.

## Operation
- States: IDLE, BEAT1, BEAT2, DONE.
- `req_ready` = (state == IDLE) & `enable`.
- Handshake: a command is taken on an edge where `req_valid` & `req_ready` are both high.
  - `aluopselect` != `3'b100`: the command is consumed and dropped. No memory access, no `done`; the unit stays in IDLE.
  - MEM_WRITE with an illegal size: go to DONE with `err` latched to 1.
  - MEM_WRITE with a legal size: latch the command and go to BEAT1.
- Alignment, with off = `addr[1:0]`:
  - Base mask is 1, 3 or F for SB, SH or SW.
  - 8-bit enable = mask << off.
  - 64-bit data = {32'b0, `wdata` masked to size} << (8·off).
  - Beat 1 uses `addr & ~3`, enables [3:0] and data [31:0].
  - Beat 2 uses (`addr & ~3`) + 4 (32-bit wrap), enables [7:4] and data [63:32].
  - Disabled lanes of `mem_wdata` are driven 0.
- BEAT1: `mem_req`=1. On `mem_ack`, go to BEAT2 if the beat-2 enables are nonzero, otherwise go to DONE.
- BEAT2: `mem_req`=1 with beat-2 fields. On `mem_ack`, go to DONE.
- DONE: `done`=1 for one cycle; `err` is valid in this cycle and 0 otherwise. Always returns to IDLE.
- `enable` is ignored outside IDLE: an in-flight store always completes.
- `mem_ack` is ignored when `mem_req`=0.
- Address wrap: a split store at 0xFFFF_FFFD..FF writes beat 2 to 0x0000_0000.

## Timing
- While `reset`=0 at an edge: go to IDLE and drive every output to 0 (`req_ready`, `mem_req`, `mem_addr`, `mem_wdata`, `mem_be`, `done`, `err`).
- After reset releases, `req_ready` follows `enable` combinationally in IDLE.
- Reset mid-operation aborts the command. `mem_req` is low after that edge, and no `done` or `err` is produced.
- Memory outputs are registered and stay stable while `mem_req`=1 and `mem_ack`=0. The memory may hold off indefinitely.
- Minimum latency, with the command accepted at edge N and zero-wait ack:
  - Aligned store: `mem_req` cycle N+1, `done` cycle N+2, `req_ready` again cycle N+3.
  - Split store: beats in cycles N+1 and N+2, `done` cycle N+3.
- Between beats, `mem_req` stays high. Address, enables and data switch on the edge where the beat-1 ack is sampled.
- Illegal size: `done`=`err`=1 in cycle N+1, with no `mem_req`.
- Throughput: at most one command per 3 cycles (aligned).

## Test plan
- SW aligned: `addr`=0x100, `wdata`=0xDEADBEEF, ack the same cycle -> one beat with `mem_addr`=0x100, `mem_be`=F, `mem_wdata`=0xDEADBEEF, then `done` one cycle later with `err`=0.
- SB at each offset: `addr`=0x203, `wdata`=0x123456A5 -> one beat with `mem_addr`=0x200, `mem_be`=8, `mem_wdata`=0xA5000000.
- SH crossing a word: `addr`=0x3FF, `wdata`=0x0000CAFE.
  - Beat 1: 0x3FC, `mem_be`=8, `mem_wdata`=0xFE000000.
  - Beat 2: 0x400, `mem_be`=1, `mem_wdata`=0x000000CA.
  - `done` follows beat 2.
- SW at offset 2 with a 3-cycle ack stall on each beat -> `mem_req` and all fields are held stable through the stall.
  - Beat 1: `mem_be`=C.
  - Beat 2: `mem_be`=3.
  - `req_ready`=0 throughout the command.
- Illegal and non-store commands:
  - `aluoperation`=`3'b111` with MEM_WRITE -> `done`=`err`=1 next cycle, no `mem_req`.
  - `aluopselect`=`3'b001` -> handshake completes, no `mem_req`, no `done`.
- Reset and enable:
  - `reset`=0 asserted during the BEAT2 stall -> all outputs 0 next cycle, no `done`.
  - `enable`=0 in IDLE -> `req_ready`=0 and the command is not taken.
